rv32i_mc_ctrl: RTL

//  Multi-cycle main controller for the RV32I core. Sequences fetch/decode/execute/memory/writeback

---
 rtl/rv32i_mc_ctrl_pkg.sv | 72 +++++++
 rtl/rv32i_opclass_dec.sv | 31 +++
 rtl/rv32i_mc_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// opcode classes and every mux-select value driven by the controller.
package rv32i_mc_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLASS_W = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned INSTR_W = 32;

  // RV32I major opcodes
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_RI     = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9,
    CLS_SYS    = 4'd10
  } class_e;

  localparam logic MEM_ADDR_PC  = 1'b0;
  localparam logic MEM_ADDR_ALU = 1'b1;

  localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'd2;

  localparam logic [SEL_W-1:0] A_RS1  = 2'd0;
  localparam logic [SEL_W-1:0] A_PC   = 2'd1;
  localparam logic [SEL_W-1:0] A_ZERO = 2'd2;

  localparam logic [SEL_W-1:0] B_RS2  = 2'd0;
  localparam logic [SEL_W-1:0] B_IMM  = 2'd1;
  localparam logic [SEL_W-1:0] B_FOUR = 2'd2;

  localparam logic [SEL_W-1:0] OP_ADD    = 2'd0;
  localparam logic [SEL_W-1:0] OP_FUNCT  = 2'd1;
  localparam logic [SEL_W-1:0] OP_BRANCH = 2'd2;
  localparam logic [SEL_W-1:0] OP_PASSB  = 2'd3;

  localparam logic [SEL_W-1:0] PC_PLUS4 = 2'd0;
  localparam logic [SEL_W-1:0] PC_JALR  = 2'd1;
  localparam logic [SEL_W-1:0] PC_REL   = 2'd2;

endpackage

// File: rtl/rv32i_opclass_dec.sv
// Combinational opcode classifier: maps instr[6:0] to an instruction class,
// flagging anything outside the supported RV32I base set as illegal.
module rv32i_opclass_dec
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output class_e           op_class,
  output logic             illegal
);

  always_comb begin
    op_class = CLS_NONE;
    illegal  = 1'b0;
    case (opcode)
      OPC_OP:       op_class = CLS_R;
      OPC_OP_IMM:   op_class = CLS_RI;
      OPC_LOAD:     op_class = CLS_LOAD;
      OPC_STORE:    op_class = CLS_STORE;
      OPC_BRANCH:   op_class = CLS_BRANCH;
      OPC_JAL:      op_class = CLS_JAL;
      OPC_JALR:     op_class = CLS_JALR;
      OPC_LUI:      op_class = CLS_LUI;
      OPC_AUIPC:    op_class = CLS_AUIPC;
      // FENCE and ECALL/EBREAK/CSR are retired as no-ops
      OPC_MISC_MEM,
      OPC_SYSTEM:   op_class = CLS_SYS;
      default:      illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/
// writeback over one memory port and one ALU, driving all datapath selects.
module rv32i_mc_ctrl
  import rv32i_mc_ctrl_pkg::*;
#(
  parameter bit RESET_TRAP_STICKY = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  input  logic               br_taken,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_we,
  output logic               rf_we,
  output logic [SEL_W-1:0]   wb_sel,
  output logic [SEL_W-1:0]   alu_a_sel,
  output logic [SEL_W-1:0]   alu_b_sel,
  output logic [SEL_W-1:0]   alu_op,
  output logic               pc_we,
  output logic [SEL_W-1:0]   pc_sel,
  output logic               illegal,
  output logic [STATE_W-1:0] state_dbg
);

  state_e state;
  state_e state_nxt;
  class_e op_class;
  class_e dec_class;
  logic   dec_illegal;

  // Only the opcode field steers the sequence; the rest belongs to the datapath
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[INSTR_W-1:OPC_W];

  rv32i_opclass_dec u_opclass_dec (
    .opcode   (instr[OPC_W-1:0]),
    .op_class (dec_class),
    .illegal  (dec_illegal)
  );

  // State and class registers; class is captured once per instruction in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RESET;
      op_class <= CLS_NONE;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        op_class <= dec_class;
      end
    end
  end

  assign state_dbg = state;

  // Next state and output decode from state, class register and handshake inputs
  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = MEM_ADDR_PC;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    alu_op       = OP_ADD;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    illegal      = 1'b0;

    case (state)
      ST_RESET: begin
        state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_addr_sel = MEM_ADDR_PC;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec_illegal) begin
          state_nxt = ST_TRAP;
        end else if (dec_class == CLS_SYS) begin
          pc_we     = 1'b1;
          pc_sel    = PC_PLUS4;
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_nxt = ST_WB;
        case (op_class)
          CLS_R: begin
            alu_op = OP_FUNCT;
          end
          CLS_RI: begin
            alu_b_sel = B_IMM;
            alu_op    = OP_FUNCT;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_b_sel = B_IMM;
            state_nxt = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op    = OP_BRANCH;
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_REL : PC_PLUS4;
            state_nxt = ST_FETCH;
          end
          CLS_LUI: begin
            alu_a_sel = A_ZERO;
            alu_b_sel = B_IMM;
            alu_op    = OP_PASSB;
          end
          CLS_AUIPC: begin
            alu_a_sel = A_PC;
            alu_b_sel = B_IMM;
          end
          CLS_JAL, CLS_JALR: begin
            alu_b_sel = B_IMM;
          end
          default: begin
            state_nxt = ST_FETCH;
          end
        endcase
      end

      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = MEM_ADDR_ALU;
        mem_we       = (op_class == CLS_STORE);
        if (mem_ready) begin
          if (op_class == CLS_STORE) begin
            pc_we     = 1'b1;
            pc_sel    = PC_PLUS4;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end
      end

      ST_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        state_nxt = ST_FETCH;
        case (op_class)
          CLS_LOAD: wb_sel = WB_MEM;
          CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_REL;  end
          CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
          default:  wb_sel = WB_ALU;
        endcase
      end

      ST_TRAP: begin
        illegal = 1'b1;
        if (!RESET_TRAP_STICKY) begin
          pc_we     = 1'b1;
          pc_sel    = PC_PLUS4;
          state_nxt = ST_FETCH;
        end
      end

      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

endmodule
